// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: step-driven sequential shift-add multiplier with a stored
// reference value and a three-way magnitude compare.
//
// Operand A is loaded on the first step and operand B on the second. The
// multiply then runs one shift-add iteration per cycle. The result lands in
// prod, and done pulses for one cycle.
//
// Optional feature (compile-time macro MULT_EARLY_EXIT_EN):
//   undefined - MULT always runs WIDTH iterations.
//   defined   - MULT ends after the first iteration that leaves the shifted
//               multiplier at zero, with a minimum of one iteration. The
//               product value is unchanged; only the done timing moves.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 store,
  input  logic [WIDTH-1:0]     bin,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [2*WIDTH-1:0]   prod,
  output logic [2*WIDTH-1:0]   ref_val,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           cmp
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_MULT   = 3'd2,
    S_DONE   = 3'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mplr_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    ref_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplr_shr;
  logic             last_iter;

  // One shift-add iteration: partial product, new accumulator, loop exit test
  always_comb begin
    addend    = '0;
    if (mplr_q[0]) begin
      addend = PW'(a_q) << cnt_q;
    end
    acc_sum   = acc_q + addend;
    mplr_shr  = mplr_q >> 1;
    last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
    // No set bits remain in the multiplier, so later iterations add nothing
    if (mplr_shr == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Control FSM together with all of its registered datapath and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      ref_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (step) begin
            a_q     <= bin;
            state_q <= S_WAIT_B;
          end
        end

        S_WAIT_B: begin
          if (step) begin
            b_q     <= bin;
            mplr_q  <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MULT;
          end
        end

        // step and store are deliberately not looked at here
        S_MULT: begin
          acc_q  <= acc_sum;
          mplr_q <= mplr_shr;
          cnt_q  <= cnt_q + CW'(1);
          if (last_iter) begin
            prod_q  <= acc_sum;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        // store and step are independent, so both can act on the same cycle
        S_DONE: begin
          if (store) begin
            ref_q <= prod_q;
          end
          if (step) begin
            a_q     <= bin;
            state_q <= S_WAIT_B;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign prod    = prod_q;
  assign ref_val = ref_q;
  assign state   = state_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Magnitude compare of product against reference, encoded as {GT,EQ,LT}
  assign cmp = {(prod_q > ref_q), (prod_q == ref_q), (prod_q < ref_q)};

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (WIDTH=8). It adapts the expected
// done latency when MULT_EARLY_EXIT_EN is defined.
module tb_mult_seq_ctrl;

  localparam int unsigned WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        store = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic [15:0] prod;
  logic [15:0] ref_val;
  logic [2:0]  state;
  logic        busy;
  logic        done;
  logic [2:0]  cmp;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .store   (store),
    .bin     (bin),
    .a_out   (a_out),
    .b_out   (b_out),
    .prod    (prod),
    .ref_val (ref_val),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .cmp     (cmp)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected number of MULT cycles for multiplier b
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) l = i + 1;
    end
    return l;
`else
    return int'(WIDTH);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [7:0] b);
    bin  = b;
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Called right after the step that enters MULT; walks to the done pulse
  task automatic mult_wait(input int lat, input logic [15:0] prev_prod, input logic [15:0] exp_prod);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i < lat) begin
        check("mult_busy", 32'(busy), 32'd1);
        check("mult_nodone", 32'(done), 32'd0);
        check("mult_prod_hold", 32'(prod), 32'(prev_prod));
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_state", 32'(state), 32'd3);
        check("done_busy", 32'(busy), 32'd0);
        check("done_prod", 32'(prod), 32'(exp_prod));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
    check("rst_ref", 32'(ref_val), 32'd0);
    check("rst_a", 32'(a_out), 32'd0);
    check("rst_b", 32'(b_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmp", 32'(cmp), 32'(CMP_EQ));
    rst = 1'b1;
    tick();

    // store in IDLE is ignored
    store = 1'b1;
    tick();
    store = 1'b0;
    check("idle_store_ref", 32'(ref_val), 32'd0);
    check("idle_store_state", 32'(state), 32'd0);

    // 0x0C x 0x0A = 0x0078
    do_step(8'h0C);
    check("s1_state", 32'(state), 32'd1);
    check("s1_a", 32'(a_out), 32'h0C);
    store = 1'b1;
    tick();
    store = 1'b0;
    check("waitb_store_state", 32'(state), 32'd1);
    check("waitb_store_ref", 32'(ref_val), 32'd0);
    do_step(8'h0A);
    check("s2_state", 32'(state), 32'd2);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_b", 32'(b_out), 32'h0A);
    mult_wait(exp_lat(8'h0A), 16'h0000, 16'h0078);
    check("t1_cmp_gt", 32'(cmp), 32'(CMP_GT));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_hold_state", 32'(state), 32'd3);

    // From DONE: new A. Store in WAIT_B and MULT, and step in MULT, are all ignored.
    do_step(8'h03);
    check("redo_state", 32'(state), 32'd1);
    check("redo_a", 32'(a_out), 32'h03);
    check("redo_b_kept", 32'(b_out), 32'h0A);
    check("redo_prod_kept", 32'(prod), 32'h0078);
    store = 1'b1;
    tick();
    store = 1'b0;
    check("waitb_store_ref2", 32'(ref_val), 32'd0);
    do_step(8'h0A);
    begin
      int lat;
      lat = exp_lat(8'h0A);
      for (int i = 1; i <= lat; i++) begin
        if (i == 2) store = 1'b1;
        if (i == 3) begin
          step = 1'b1;
          bin  = 8'h55;
        end
        tick();
        store = 1'b0;
        step  = 1'b0;
        if (i < lat) begin
          check("ign_state", 32'(state), 32'd2);
          check("ign_a", 32'(a_out), 32'h03);
          check("ign_done", 32'(done), 32'd0);
        end else begin
          check("ign_done_pulse", 32'(done), 32'd1);
          check("ign_prod", 32'(prod), 32'h001E);
        end
        check("ign_ref", 32'(ref_val), 32'd0);
      end
    end

    // Store and step in the same DONE cycle with prod=0x0078
    do_step(8'h0C);
    do_step(8'h0A);
    mult_wait(exp_lat(8'h0A), 16'h001E, 16'h0078);
    store = 1'b1;
    step  = 1'b1;
    bin   = 8'h03;
    tick();
    store = 1'b0;
    step  = 1'b0;
    check("both_ref", 32'(ref_val), 32'h0078);
    check("both_a", 32'(a_out), 32'h03);
    check("both_state", 32'(state), 32'd1);
    do_step(8'h02);
    mult_wait(exp_lat(8'h02), 16'h0078, 16'h0006);
    check("both_cmp_lt", 32'(cmp), 32'(CMP_LT));

    // Maximum operands, then store
    do_step(8'hFF);
    do_step(8'hFF);
    mult_wait(exp_lat(8'hFF), 16'h0006, 16'hFE01);
    check("max_cmp_gt", 32'(cmp), 32'(CMP_GT));
    store = 1'b1;
    tick();
    store = 1'b0;
    check("max_store_ref", 32'(ref_val), 32'hFE01);
    check("max_store_cmp", 32'(cmp), 32'(CMP_EQ));

    // 0x05 x 0x01: one cycle with early exit, WIDTH cycles without
    do_step(8'h05);
    do_step(8'h01);
    mult_wait(exp_lat(8'h01), 16'hFE01, 16'h0005);
    check("ee_cmp_lt", 32'(cmp), 32'(CMP_LT));
    do_step(8'h05);
    do_step(8'h00);
    mult_wait(exp_lat(8'h00), 16'h0005, 16'h0000);

    // Reset asserted during MULT cycle 4
    do_step(8'h07);
    do_step(8'h89);
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_a", 32'(a_out), 32'd0);
    check("mrst_b", 32'(b_out), 32'd0);
    check("mrst_prod", 32'(prod), 32'd0);
    check("mrst_ref", 32'(ref_val), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_cmp", 32'(cmp), 32'(CMP_EQ));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_hold_done", 32'(done), 32'd0);
      check("mrst_hold_state", 32'(state), 32'd0);
    end
    rst = 1'b1;
    tick();
    do_step(8'h04);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_a", 32'(a_out), 32'h04);
    check("post_rst_cmp", 32'(cmp), 32'(CMP_EQ));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
